abcd_chk_strip: RTL and testbench
=================================

ABCD_CHK_STRIP -- requirements
Module: abcd_chk_strip

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 512, data width in bits (multiple of 32).
REQ-002 SHALL have parameter AXIS_ID_WIDTH, default 6, tid width in bits.
REQ-003 SHALL have port aclk, input, 1: sole clock, rising edge; one clock domain.
REQ-004 SHALL have port areset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axis_tvalid/tready/tdata/tkeep/tid/tlast: in/out/in/in/in/in, widths 1/1/AXIS_TDATA_WIDTH/AXIS_TDATA_WIDTH/8/AXIS_ID_WIDTH/1; this is the checksummed input stream.
REQ-006 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tid/tlast: out/in/out/out/out/out, same widths; this is the stripped data stream.
REQ-007 SHALL have port err_valid, output, 1: one-cycle pulse per checksum mismatch.
REQ-008 SHALL have port err_id, output, AXIS_ID_WIDTH: tid of the mismatching packet, valid while err_valid is high.

Function
REQ-009 SHALL treat the input packet as N>=0 data beats with tlast=0, followed by one checksum beat with tlast=1 whose tdata[31:0] holds the expected checksum.
REQ-010 SHALL compute the checksum as the XOR of all 32-bit words of every data beat, with bytes whose tkeep bit is 0 forced to zero before the XOR.
REQ-011 SHALL keep one hold register H (data, keep, id, valid) and one output register O driving m_axis_*.
REQ-012 On acceptance of a data beat: if H is empty, the beat SHALL load H; if H is full, H SHALL move to O with tlast=0 and the beat SHALL load H.
REQ-013 On acceptance of a checksum beat with H full: H SHALL move to O with tlast=1, H SHALL empty, and the beat SHALL NOT be forwarded.
REQ-014 On acceptance of a checksum beat with H empty (N=0): the beat SHALL be dropped and no output beat SHALL be produced.
REQ-015 s_axis_tready SHALL be 1 when H is empty, or O is empty, or m_axis_tready=1; it SHALL depend only on registered state and m_axis_tready.
REQ-016 Once m_axis_tvalid is asserted, O SHALL hold m_axis_tvalid and all payload outputs stable until m_axis_tready=1.
REQ-017 Latency: data beat k SHALL appear on m_axis one cycle after beat k+1 is accepted; with no backpressure, throughput SHALL be one beat per cycle.
REQ-018 When the checksum beat is accepted, the block SHALL compare the accumulated checksum with tdata[31:0] and clear the accumulator in the same cycle.
REQ-019 On a mismatch, err_valid SHALL pulse high for exactly one cycle, on the cycle after the checksum beat is accepted, with err_id equal to that beat's tid.
REQ-020 A data beat accepted in the cycle after a checksum beat SHALL start a new packet with a zero accumulator, with no bubble between packets.
REQ-021 tid of data beats SHALL pass through unchanged; tid consistency within a packet SHALL NOT be checked.

Reset
REQ-022 While areset=1: m_axis_tvalid=0, s_axis_tready=0, err_valid=0, err_id=0, H and O empty, accumulator 0, all data registers 0.
REQ-023 Asserting areset in mid-packet SHALL discard the partial packet; after release, the first beat accepted SHALL start a new packet.

Configuration
REQ-024 With macro ABCD_CHK_ERR_CNT_EN defined, the block SHALL add output err_cnt (32 bits, reset 0), which increments on each err_valid pulse and saturates at 0xFFFFFFFF.
REQ-025 Without ABCD_CHK_ERR_CNT_EN, port err_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Packet of 2 beats (all words 0x1 and 0x3, keep all-ones, tid=5) plus checksum 0x0 -> two output beats, second with tlast=1, and no err_valid.
REQ-027 Same packet with checksum 0xDEADBEEF -> err_valid pulses once with err_id=5; with the macro, err_cnt=1.
REQ-028 Checksum beat only (N=0), tid=2, tdata[31:0]=0x7 -> no m_axis beat, err_valid with err_id=2.
REQ-029 Last data beat with tkeep=0x0F and words 0xFFFFFFFF -> only word 0 contributes; a checksum of 0xFFFFFFFF matches if the other beats XOR to 0.
REQ-030 Random m_axis_tready backpressure over 100 back-to-back packets -> output equals input minus the checksum beats, payload stable while stalled, no lost beats.
REQ-031 Assert areset in the middle of beat 2 of 4 -> outputs reach reset values immediately; the next full packet is stripped and checked correctly.

Source files
------------

// File: rtl/abcd_chk_strip.sv
// ---------------------------------------------------------------------------
// abcd_chk_strip
//
// Purpose:
//   Receives an AXI-Stream packet made of N >= 0 data beats followed by one
//   checksum beat (tlast=1, expected checksum in tdata[31:0]).  The data beats
//   are forwarded with tlast moved onto the last data beat; the checksum beat
//   is stripped.  The running checksum is the XOR of all 32-bit words of the
//   data beats, with bytes whose tkeep bit is low forced to zero.  A mismatch
//   produces a one-cycle err_valid pulse tagged with the checksum beat's tid.
//
//   One data beat is always held back in a hold register so that tlast can
//   be attached once the following beat shows whether it was the checksum.
//
// Ports:
//   aclk, areset         clock (rising edge) and async active-high reset
//   s_axis_*             checksummed input stream (tvalid/tready/tdata/tkeep/
//                        tid/tlast)
//   m_axis_*             stripped output stream, same fields
//   err_valid            one-cycle pulse per checksum mismatch
//   err_id               tid of the mismatching packet, valid with err_valid
//   err_cnt              (only with ABCD_CHK_ERR_CNT_EN) saturating 32-bit
//                        count of err_valid pulses
//
// Configuration macro:
//   ABCD_CHK_ERR_CNT_EN  adds the err_cnt output and its counter
// ---------------------------------------------------------------------------
module abcd_chk_strip #(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int AXIS_ID_WIDTH    = 6
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [AXIS_ID_WIDTH-1:0]      s_axis_tid,
  input  logic                          s_axis_tlast,

  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXIS_ID_WIDTH-1:0]      m_axis_tid,
  output logic                          m_axis_tlast,

  output logic                          err_valid,
  output logic [AXIS_ID_WIDTH-1:0]      err_id
`ifdef ABCD_CHK_ERR_CNT_EN
  ,
  output logic [31:0]                   err_cnt
`endif
);

  localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;
  localparam int WORDS  = AXIS_TDATA_WIDTH / 32;

  // Hold register H: the most recent data beat, not yet known to be last.
  logic [AXIS_TDATA_WIDTH-1:0] h_data;
  logic [KEEP_W-1:0]           h_keep;
  logic [AXIS_ID_WIDTH-1:0]    h_id;
  logic                        h_valid;

  // Output register O: drives m_axis directly.
  logic [AXIS_TDATA_WIDTH-1:0] o_data;
  logic [KEEP_W-1:0]           o_keep;
  logic [AXIS_ID_WIDTH-1:0]    o_id;
  logic                        o_last;
  logic                        o_valid;

  // Keeps s_axis_tready low while in reset without a combinational path
  // from areset; it rises on the first clock edge after reset release.
  logic                        ready_en;

  logic [31:0]                 acc;
  logic [31:0]                 beat_xor;
  logic                        accept;
  logic                        data_beat;
  logic                        chk_beat;

  assign s_axis_tready = ready_en & (~h_valid | ~o_valid | m_axis_tready);

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign data_beat = accept & ~s_axis_tlast;
  assign chk_beat  = accept &  s_axis_tlast;

  assign m_axis_tvalid = o_valid;
  assign m_axis_tdata  = o_data;
  assign m_axis_tkeep  = o_keep;
  assign m_axis_tid    = o_id;
  assign m_axis_tlast  = o_last;

  // XOR of all 32-bit words of the incoming beat with unkept bytes zeroed.
  always_comb begin
    beat_xor = '0;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axis_tkeep[w*4 + b]) begin
          beat_xor[b*8 +: 8] = beat_xor[b*8 +: 8] ^ s_axis_tdata[w*32 + b*8 +: 8];
        end
      end
    end
  end

  // Data path: any accepted beat pushes a full H into O. The checksum beat
  // marks that pushed beat as last and empties H; it is never forwarded.
  // A checksum beat arriving with H empty (empty packet) changes nothing
  // here. O only drains when no new beat is being pushed into it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en <= 1'b0;
      h_data   <= '0;
      h_keep   <= '0;
      h_id     <= '0;
      h_valid  <= 1'b0;
      o_data   <= '0;
      o_keep   <= '0;
      o_id     <= '0;
      o_last   <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (accept && h_valid) begin
        o_data  <= h_data;
        o_keep  <= h_keep;
        o_id    <= h_id;
        o_last  <= s_axis_tlast;
        o_valid <= 1'b1;
      end else if (m_axis_tready) begin
        o_valid <= 1'b0;
      end

      if (data_beat) begin
        h_data  <= s_axis_tdata;
        h_keep  <= s_axis_tkeep;
        h_id    <= s_axis_tid;
        h_valid <= 1'b1;
      end else if (chk_beat) begin
        h_valid <= 1'b0;
      end
    end
  end

  // Checksum accumulation and compare. The accumulator is cleared on the
  // checksum beat so a data beat in the very next cycle starts a fresh
  // packet. err_valid is registered, giving a single pulse one cycle after
  // the checksum beat is accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc       <= '0;
      err_valid <= 1'b0;
      err_id    <= '0;
    end else begin
      err_valid <= 1'b0;
      if (data_beat) begin
        acc <= acc ^ beat_xor;
      end else if (chk_beat) begin
        acc       <= '0;
        err_valid <= (acc != s_axis_tdata[31:0]);
        err_id    <= s_axis_tid;
      end
    end
  end

`ifdef ABCD_CHK_ERR_CNT_EN
  // Saturating error counter, advancing on each err_valid pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_cnt <= '0;
    end else if (err_valid && (err_cnt != 32'hFFFF_FFFF)) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_abcd_chk_strip.sv
// ---------------------------------------------------------------------------
// tb_abcd_chk_strip
//
// Purpose:
//   Self-checking bench for abcd_chk_strip. Packets are built in the bench,
//   their expected output beats and expected error tids are queued when the
//   packet is issued, and independent monitors pop and compare whatever the
//   DUT presents on m_axis and err_valid.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_abcd_chk_strip;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int IW    = 6;
  localparam int WORDS = DW / 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic          aclk;
  logic          areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [IW-1:0] s_axis_tid;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [IW-1:0] m_axis_tid;
  logic          m_axis_tlast;
  logic          err_valid;
  logic [IW-1:0] err_id;
`ifdef ABCD_CHK_ERR_CNT_EN
  logic [31:0]   err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int err_total = 0;
  int ready_mode = 2;

  beat_t         exp_q[$];
  logic [IW-1:0] err_q[$];
  beat_t         cur_data[$];

  abcd_chk_strip #(
    .AXIS_TDATA_WIDTH(DW),
    .AXIS_ID_WIDTH(IW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tid(m_axis_tid),
    .m_axis_tlast(m_axis_tlast),
    .err_valid(err_valid),
    .err_id(err_id)
`ifdef ABCD_CHK_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Downstream ready: always on, random backpressure, or held off.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 2) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference checksum straight from the packet definition: XOR of every
  // 32-bit word of every data beat, each word ANDed with its byte-keep mask.
  function automatic logic [31:0] model_checksum();
    logic [31:0] sum;
    logic [31:0] mask;
    sum = '0;
    foreach (cur_data[i]) begin
      for (int w = 0; w < WORDS; w++) begin
        mask = {{8{cur_data[i].keep[w*4+3]}}, {8{cur_data[i].keep[w*4+2]}},
                {8{cur_data[i].keep[w*4+1]}}, {8{cur_data[i].keep[w*4]}}};
        sum = sum ^ (cur_data[i].data[w*32 +: 32] & mask);
      end
    end
    return sum;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] fill_words(input logic [31:0] v);
    logic [DW-1:0] d;
    for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = v;
    return d;
  endfunction

  function automatic beat_t make_beat(input logic [DW-1:0] d,
                                      input logic [KW-1:0] k,
                                      input logic [IW-1:0] id);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.id   = id;
    b.last = 1'b0;
    return b;
  endfunction

  // Presents one beat and waits for its handshake. Entered and left at
  // posedge+1 so consecutive calls are back to back.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [IW-1:0] id, input logic last);
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tid    = id;
    s_axis_tlast  = last;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_axis_tready && n < 2000);
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: got tready=0 expected tready=1");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Sends cur_data followed by a checksum beat. When push_exp is set the
  // expected output beats and any expected error are queued first.
  task automatic applyStimulus(input logic [IW-1:0] ck_id,
                               input logic [31:0] ck_value,
                               input bit push_exp);
    beat_t         e;
    logic [DW-1:0] ck_data;
    if (push_exp) begin
      foreach (cur_data[i]) begin
        e = cur_data[i];
        e.last = (i == cur_data.size() - 1);
        exp_q.push_back(e);
      end
      if (model_checksum() != ck_value) begin
        err_q.push_back(ck_id);
        err_total++;
      end
    end
    foreach (cur_data[i])
      drive_beat(cur_data[i].data, cur_data[i].keep, cur_data[i].id, 1'b0);
    ck_data = rand_data();
    ck_data[31:0] = ck_value;
    drive_beat(ck_data, {$urandom, $urandom}, ck_id, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    checkOutput("drain_exp_q", DW'(exp_q.size()), DW'(0));
    checkOutput("drain_err_q", DW'(err_q.size()), DW'(0));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_m_tvalid"}, DW'(m_axis_tvalid), DW'(0));
    checkOutput({tag, "_s_tready"}, DW'(s_axis_tready), DW'(0));
    checkOutput({tag, "_err_valid"}, DW'(err_valid), DW'(0));
    checkOutput({tag, "_err_id"}, DW'(err_id), DW'(0));
    checkOutput({tag, "_m_tdata"}, m_axis_tdata, DW'(0));
  endtask

  // Output monitor: compares every transferred beat against the queue and
  // verifies that a stalled beat stays unchanged until it is taken.
  beat_t prev;
  bit    stalled = 0;
  always @(negedge aclk) begin
    beat_t e;
    if (areset) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checkOutput("stall_tvalid", DW'(m_axis_tvalid), DW'(1));
        checkOutput("stall_tdata", m_axis_tdata, prev.data);
        checkOutput("stall_ctrl", DW'({m_axis_tkeep, m_axis_tid, m_axis_tlast}),
                    DW'({prev.keep, prev.id, prev.last}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got tid=%0d expected no beat", m_axis_tid);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_tdata", m_axis_tdata, e.data);
          checkOutput("out_tkeep", DW'(m_axis_tkeep), DW'(e.keep));
          checkOutput("out_tid", DW'(m_axis_tid), DW'(e.id));
          checkOutput("out_tlast", DW'(m_axis_tlast), DW'(e.last));
        end
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      prev.data = m_axis_tdata;
      prev.keep = m_axis_tkeep;
      prev.id   = m_axis_tid;
      prev.last = m_axis_tlast;
    end
  end

  // Error monitor.
  always @(negedge aclk) begin
    if (!areset && err_valid) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_err: got err_id=%0d expected no error", err_id);
      end else begin
        checkOutput("err_id", DW'(err_id), DW'(err_q.pop_front()));
      end
    end
  end

  initial begin
    int            n;
    logic [KW-1:0] k;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    areset        = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_values("init_reset");
    areset = 1'b0;
    ready_mode = 0;
    @(posedge aclk);
    #1;

    // Two beats of 0x1 and 0x3 words: checksum 0 matches.
    $display("[TB] directed: two-beat packet, good checksum");
    cur_data.delete();
    cur_data.push_back(make_beat(fill_words(32'h1), '1, 6'd5));
    cur_data.push_back(make_beat(fill_words(32'h3), '1, 6'd5));
    applyStimulus(6'd5, 32'h0, 1);

    // Same packet, wrong checksum.
    $display("[TB] directed: two-beat packet, bad checksum");
    applyStimulus(6'd5, 32'hDEAD_BEEF, 1);

    // Checksum beat only.
    $display("[TB] directed: empty packet");
    cur_data.delete();
    applyStimulus(6'd2, 32'h7, 1);

    // Partial keep on the last data beat: only word 0 contributes.
    $display("[TB] directed: partial tkeep");
    cur_data.delete();
    cur_data.push_back(make_beat(fill_words(32'h5), '1, 6'd9));
    cur_data.push_back(make_beat(fill_words(32'hFFFF_FFFF), KW'(64'h0F), 6'd9));
    applyStimulus(6'd9, 32'hFFFF_FFFF, 1);
    wait_drain();
`ifdef ABCD_CHK_ERR_CNT_EN
    checkOutput("err_cnt_directed", DW'(err_cnt), DW'(err_total));
`endif

    // Random back-to-back packets with random backpressure.
    $display("[TB] random: 100 packets with backpressure");
    ready_mode = 1;
    for (int p = 0; p < 100; p++) begin
      cur_data.delete();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        k = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
        cur_data.push_back(make_beat(rand_data(), k, IW'($urandom)));
      end
      if ($urandom_range(0, 1) == 0)
        applyStimulus(IW'($urandom), model_checksum(), 1);
      else
        applyStimulus(IW'($urandom), model_checksum() ^ ($urandom | 32'h1), 1);
    end
    wait_drain();
`ifdef ABCD_CHK_ERR_CNT_EN
    checkOutput("err_cnt_random", DW'(err_cnt), DW'(err_total));
`endif

    // Reset in the middle of a 4-beat packet with the output stalled.
    $display("[TB] directed: reset mid-packet");
    ready_mode = 2;
    @(posedge aclk);
    #1;
    drive_beat(rand_data(), '1, 6'd3, 1'b0);
    drive_beat(rand_data(), '1, 6'd3, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand_data();
    s_axis_tkeep  = '1;
    s_axis_tid    = 6'd3;
    s_axis_tlast  = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    s_axis_tvalid = 1'b0;
    ready_mode = 0;
    err_total = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    cur_data.delete();
    for (int i = 0; i < 4; i++)
      cur_data.push_back(make_beat(rand_data(), '1, 6'd4));
    applyStimulus(6'd4, model_checksum(), 1);
    applyStimulus(6'd4, model_checksum() ^ 32'h1, 1);
    wait_drain();
`ifdef ABCD_CHK_ERR_CNT_EN
    checkOutput("err_cnt_after_reset", DW'(err_cnt), DW'(err_total));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
